present_cipher_core: RTL and testbench

- Parametrised PRESENT block cipher engine: one engine for both encryption and decryption, with 80-bit or 128-bit keys.
- Iterative datapath: one round per clock, with a ready/start request handshake and a one-cycle done pulse.
- Adds a last-round-key cache. A decrypt under the most recently used key skips the 31-cycle forward key expansion.
- Sits in the crypto peripheral behind the bus wrapper, as the successor to the fixed 80-bit decrypt-only core.

---
 rtl/present_cipher_core_if.sv | 27 ++
 rtl/present_cipher_core.sv | 257 +++++++++++++++++++++++++
 tb/tb_present_cipher_core.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/present_cipher_core_if.sv
// Request/result bundle for present_cipher_core.
// master : drives start, mode, idat, key; observes ready, busy, odat, done, cache_hit.
// slave  : the cipher core side of the same signals.
// KEY_WIDTH must match the KEY_WIDTH of the core the bundle is bound to.
interface present_cipher_core_if #(
    parameter int KEY_WIDTH = 80
);
    logic                 start;
    logic                 mode;
    logic [63:0]          idat;
    logic [KEY_WIDTH-1:0] key;
    logic                 ready;
    logic                 busy;
    logic [63:0]          odat;
    logic                 done;
    logic                 cache_hit;

    modport master (
        output start, mode, idat, key,
        input  ready, busy, odat, done, cache_hit
    );

    modport slave (
        input  start, mode, idat, key,
        output ready, busy, odat, done, cache_hit
    );
endinterface

// File: rtl/present_cipher_core.sv
// Iterative PRESENT block cipher (encrypt and decrypt, 80- or 128-bit key).
// One round per enabled clock edge. A decrypt normally first expands the key
// forward to K32 (31 edges); the last key expanded or used for encryption is
// cached together with its K32, so a decrypt under that key starts at once.
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset (wins over chip_enable)
//   chip_enable  global stall when low; every register holds
//   bus          slave side of present_cipher_core_if:
//                start/mode/idat/key in, ready/busy/odat/done/cache_hit out
module present_cipher_core #(
    parameter int KEY_WIDTH = 80,
    parameter int ROUNDS    = 31
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  chip_enable,
    present_cipher_core_if.slave  bus
);

    // Only the two standard key sizes and round count are supported.
    generate
        if (!(KEY_WIDTH == 80 || KEY_WIDTH == 128)) begin : g_bad_key_width
            $error("present_cipher_core: KEY_WIDTH must be 80 or 128");
        end
        if (ROUNDS != 31) begin : g_bad_rounds
            $error("present_cipher_core: ROUNDS must be 31");
        end
    endgenerate

    // Position of the 5-bit round-counter XOR inside the key register.
    localparam int         RC_LSB   = (KEY_WIDTH == 80) ? 15 : 62;
    localparam logic [4:0] LAST_RND = 5'(ROUNDS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        KEYEXP = 2'd1,
        ROUND  = 2'd2,
        FINAL  = 2'd3
    } state_t;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        case (x)
            4'h0: sbox4 = 4'hC;  4'h1: sbox4 = 4'h5;  4'h2: sbox4 = 4'h6;  4'h3: sbox4 = 4'hB;
            4'h4: sbox4 = 4'h9;  4'h5: sbox4 = 4'h0;  4'h6: sbox4 = 4'hA;  4'h7: sbox4 = 4'hD;
            4'h8: sbox4 = 4'h3;  4'h9: sbox4 = 4'hE;  4'hA: sbox4 = 4'hF;  4'hB: sbox4 = 4'h8;
            4'hC: sbox4 = 4'h4;  4'hD: sbox4 = 4'h7;  4'hE: sbox4 = 4'h1;  4'hF: sbox4 = 4'h2;
            default: sbox4 = 4'h0;
        endcase
    endfunction

    function automatic logic [3:0] inv_sbox4(input logic [3:0] x);
        case (x)
            4'h0: inv_sbox4 = 4'h5;  4'h1: inv_sbox4 = 4'hE;  4'h2: inv_sbox4 = 4'hF;  4'h3: inv_sbox4 = 4'h8;
            4'h4: inv_sbox4 = 4'hC;  4'h5: inv_sbox4 = 4'h1;  4'h6: inv_sbox4 = 4'h2;  4'h7: inv_sbox4 = 4'hD;
            4'h8: inv_sbox4 = 4'hB;  4'h9: inv_sbox4 = 4'h4;  4'hA: inv_sbox4 = 4'h6;  4'hB: inv_sbox4 = 4'h3;
            4'hC: inv_sbox4 = 4'h0;  4'hD: inv_sbox4 = 4'h7;  4'hE: inv_sbox4 = 4'h9;  4'hF: inv_sbox4 = 4'hA;
            default: inv_sbox4 = 4'h0;
        endcase
    endfunction

    function automatic logic [63:0] sbox_layer(input logic [63:0] x);
        logic [63:0] y;
        y = 64'd0;
        for (int i = 0; i < 16; i++) begin
            y[4*i +: 4] = sbox4(x[4*i +: 4]);
        end
        return y;
    endfunction

    function automatic logic [63:0] inv_sbox_layer(input logic [63:0] x);
        logic [63:0] y;
        y = 64'd0;
        for (int i = 0; i < 16; i++) begin
            y[4*i +: 4] = inv_sbox4(x[4*i +: 4]);
        end
        return y;
    endfunction

    // Bit i moves to 16*i mod 63; bit 63 stays put.
    function automatic logic [63:0] p_layer(input logic [63:0] x);
        logic [63:0] y;
        y = 64'd0;
        for (int i = 0; i < 63; i++) begin
            y[(i * 16) % 63] = x[i];
        end
        y[63] = x[63];
        return y;
    endfunction

    function automatic logic [63:0] inv_p_layer(input logic [63:0] x);
        logic [63:0] y;
        y = 64'd0;
        for (int i = 0; i < 63; i++) begin
            y[i] = x[(i * 16) % 63];
        end
        y[63] = x[63];
        return y;
    endfunction

    // Forward key schedule step: rotate left 61, S-box top nibble(s), XOR round counter.
    function automatic logic [KEY_WIDTH-1:0] key_update(input logic [KEY_WIDTH-1:0] k,
                                                        input logic [4:0] rc);
        logic [KEY_WIDTH-1:0] t;
        t = {k[KEY_WIDTH-62:0], k[KEY_WIDTH-1:KEY_WIDTH-61]};
        t[KEY_WIDTH-1 -: 4] = sbox4(t[KEY_WIDTH-1 -: 4]);
        t[KEY_WIDTH-5 -: 4] = (KEY_WIDTH == 128) ? sbox4(t[KEY_WIDTH-5 -: 4]) : t[KEY_WIDTH-5 -: 4];
        t[RC_LSB +: 5] = t[RC_LSB +: 5] ^ rc;
        return t;
    endfunction

    // Exact inverse of key_update for the same round counter.
    function automatic logic [KEY_WIDTH-1:0] inv_key_update(input logic [KEY_WIDTH-1:0] k,
                                                            input logic [4:0] rc);
        logic [KEY_WIDTH-1:0] t;
        t = k;
        t[RC_LSB +: 5] = t[RC_LSB +: 5] ^ rc;
        t[KEY_WIDTH-1 -: 4] = inv_sbox4(t[KEY_WIDTH-1 -: 4]);
        t[KEY_WIDTH-5 -: 4] = (KEY_WIDTH == 128) ? inv_sbox4(t[KEY_WIDTH-5 -: 4]) : t[KEY_WIDTH-5 -: 4];
        return {t[60:0], t[KEY_WIDTH-1:61]};
    endfunction

    state_t               state_r;
    logic [4:0]           rnd_r;
    logic                 mode_r;
    logic [63:0]          data_r;
    logic [KEY_WIDTH-1:0] key_r;
    logic [KEY_WIDTH-1:0] orig_key_r;
    logic                 cache_valid_r;
    logic [KEY_WIDTH-1:0] cache_key_r;
    logic [KEY_WIDTH-1:0] cache_k32_r;
    logic                 ready_r;
    logic                 busy_r;
    logic [63:0]          odat_r;
    logic                 done_r;
    logic                 cache_hit_r;

    logic [63:0]          mixed_s;
    logic [63:0]          enc_next_s;
    logic [63:0]          dec_next_s;
    logic [KEY_WIDTH-1:0] key_fwd_s;
    logic [KEY_WIDTH-1:0] key_inv_s;
    logic                 cache_match_s;

    // Round key is always the top 64 bits of the key register.
    assign mixed_s    = data_r ^ key_r[KEY_WIDTH-1 -: 64];
    assign enc_next_s = p_layer(sbox_layer(mixed_s));
    assign dec_next_s = inv_sbox_layer(inv_p_layer(mixed_s));
    assign key_fwd_s  = key_update(key_r, rnd_r);
    // Decrypt round r undoes forward step 32-r; modulo 32 that is just -r.
    assign key_inv_s  = inv_key_update(key_r, 5'd0 - rnd_r);
    assign cache_match_s = cache_valid_r && (cache_key_r == bus.key);

    assign bus.ready     = ready_r;
    assign bus.busy      = busy_r;
    assign bus.odat      = odat_r;
    assign bus.done      = done_r;
    assign bus.cache_hit = cache_hit_r;

    // Control FSM, datapath, key cache and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            rnd_r         <= 5'd0;
            mode_r        <= 1'b0;
            data_r        <= 64'd0;
            key_r         <= '0;
            orig_key_r    <= '0;
            cache_valid_r <= 1'b0;
            cache_key_r   <= '0;
            cache_k32_r   <= '0;
            ready_r       <= 1'b1;
            busy_r        <= 1'b0;
            odat_r        <= 64'd0;
            done_r        <= 1'b0;
            cache_hit_r   <= 1'b0;
        end else if (chip_enable) begin
            done_r      <= 1'b0;
            cache_hit_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        data_r     <= bus.idat;
                        orig_key_r <= bus.key;
                        mode_r     <= bus.mode;
                        rnd_r      <= 5'd1;
                        ready_r    <= 1'b0;
                        busy_r     <= 1'b1;
                        if (!bus.mode) begin
                            key_r   <= bus.key;
                            state_r <= ROUND;
                        end else if (cache_match_s) begin
                            key_r       <= cache_k32_r;
                            cache_hit_r <= 1'b1;
                            state_r     <= ROUND;
                        end else begin
                            key_r   <= bus.key;
                            state_r <= KEYEXP;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                KEYEXP: begin
                    key_r <= key_fwd_s;
                    if (rnd_r == LAST_RND) begin
                        // key_fwd_s is K32 here: remember it for later decrypts.
                        rnd_r         <= 5'd1;
                        state_r       <= ROUND;
                        cache_key_r   <= orig_key_r;
                        cache_k32_r   <= key_fwd_s;
                        cache_valid_r <= 1'b1;
                    end else begin
                        rnd_r <= rnd_r + 5'd1;
                    end
                end
                ROUND: begin
                    if (mode_r) begin
                        data_r <= dec_next_s;
                        key_r  <= key_inv_s;
                    end else begin
                        data_r <= enc_next_s;
                        key_r  <= key_fwd_s;
                    end
                    if (rnd_r == LAST_RND) begin
                        state_r <= FINAL;
                    end else begin
                        rnd_r <= rnd_r + 5'd1;
                    end
                end
                FINAL: begin
                    // key_r holds K32 after encrypt rounds, K1 after decrypt rounds.
                    odat_r  <= mixed_s;
                    done_r  <= 1'b1;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                    if (!mode_r) begin
                        cache_key_r   <= orig_key_r;
                        cache_k32_r   <= key_r;
                        cache_valid_r <= 1'b1;
                    end else begin
                        cache_valid_r <= cache_valid_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end else begin
            state_r <= state_r;
        end
    end

endmodule

// File: tb/tb_present_cipher_core.sv
// Self-checking bench for present_cipher_core: one 80-bit and one 128-bit
// instance, published vectors, a reference model with forward-only key
// schedule, a cache/latency model and a scoreboard queue of expected results.
module tb_present_cipher_core;

    logic         clk;
    logic         rst;
    logic         chip_enable;
    logic         tb_start;
    logic         tb_mode;
    logic [63:0]  tb_idat;
    logic [127:0] tb_key;
    logic         use128;

    present_cipher_core_if #(.KEY_WIDTH(80))  if80 ();
    present_cipher_core_if #(.KEY_WIDTH(128)) if128 ();

    assign if80.start  = tb_start & ~use128;
    assign if80.mode   = tb_mode;
    assign if80.idat   = tb_idat;
    assign if80.key    = tb_key[79:0];
    assign if128.start = tb_start & use128;
    assign if128.mode  = tb_mode;
    assign if128.idat  = tb_idat;
    assign if128.key   = tb_key;

    present_cipher_core #(.KEY_WIDTH(80), .ROUNDS(31)) dut80 (
        .clk(clk), .rst(rst), .chip_enable(chip_enable), .bus(if80));
    present_cipher_core #(.KEY_WIDTH(128), .ROUNDS(31)) dut128 (
        .clk(clk), .rst(rst), .chip_enable(chip_enable), .bus(if128));

    logic        s_done, s_hit, s_ready, s_busy;
    logic [63:0] s_odat;
    assign s_done  = use128 ? if128.done      : if80.done;
    assign s_hit   = use128 ? if128.cache_hit : if80.cache_hit;
    assign s_ready = use128 ? if128.ready     : if80.ready;
    assign s_busy  = use128 ? if128.busy      : if80.busy;
    assign s_odat  = use128 ? if128.odat      : if80.odat;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [63:0] odat;
        logic        hit;
        logic [7:0]  lat;
    } exp_t;
    exp_t sb[$];

    logic         cm_valid80, cm_valid128;
    logic [127:0] cm_key80, cm_key128;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [3:0] m_s(input logic [3:0] x);
        logic [63:0] tbl;
        tbl = 64'h2174_8FE3_DA09_B65C;
        return tbl[4*x +: 4];
    endfunction

    function automatic logic [3:0] m_sinv(input logic [3:0] x);
        logic [3:0] r;
        r = 4'h0;
        for (int v = 0; v < 16; v++) begin
            if (m_s(4'(v)) == x) r = 4'(v);
        end
        return r;
    endfunction

    function automatic logic [63:0] m_sub(input logic [63:0] x, input bit inv);
        logic [63:0] y;
        for (int i = 0; i < 16; i++) y[4*i +: 4] = inv ? m_sinv(x[4*i +: 4]) : m_s(x[4*i +: 4]);
        return y;
    endfunction

    function automatic logic [63:0] m_perm(input logic [63:0] x, input bit inv);
        logic [63:0] y;
        y[63] = x[63];
        for (int i = 0; i < 63; i++) begin
            if (inv) y[i] = x[(16 * i) % 63];
            else     y[(16 * i) % 63] = x[i];
        end
        return y;
    endfunction

    function automatic logic [127:0] m_kupd(input logic [127:0] k, input int kw, input logic [4:0] rc);
        logic [127:0] t;
        t = 128'd0;
        if (kw == 80) begin
            t[79:0]   = {k[18:0], k[79:19]};
            t[79:76]  = m_s(t[79:76]);
            t[19:15]  = t[19:15] ^ rc;
        end else begin
            t          = {k[66:0], k[127:67]};
            t[127:124] = m_s(t[127:124]);
            t[123:120] = m_s(t[123:120]);
            t[66:62]   = t[66:62] ^ rc;
        end
        return t;
    endfunction

    function automatic logic [63:0] m_rk(input logic [127:0] k, input int kw, input int idx);
        logic [127:0] t;
        t = k;
        for (int j = 1; j < idx; j++) t = m_kupd(t, kw, 5'(j));
        return (kw == 80) ? t[79:16] : t[127:64];
    endfunction

    function automatic logic [63:0] m_enc(input logic [63:0] d, input logic [127:0] k, input int kw);
        logic [63:0] x;
        x = d;
        for (int i = 1; i <= 31; i++) x = m_perm(m_sub(x ^ m_rk(k, kw, i), 1'b0), 1'b0);
        return x ^ m_rk(k, kw, 32);
    endfunction

    function automatic logic [63:0] m_dec(input logic [63:0] c, input logic [127:0] k, input int kw);
        logic [63:0] x;
        x = c ^ m_rk(k, kw, 32);
        for (int i = 31; i >= 1; i--) x = m_sub(m_perm(x, 1'b1), 1'b1) ^ m_rk(k, kw, i);
        return x;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cm_valid80  = 1'b0;
        cm_valid128 = 1'b0;
    endtask

    // Apply one request, push its expectation, then wait for done and compare.
    task automatic run_op(input logic w128, input logic m, input logic [63:0] d,
                          input logic [127:0] k, input logic [63:0] exp_o, input logic stress);
        logic hit;
        int   lat, cyc, gap_at, extra;
        exp_t e;
        hit = m && (w128 ? (cm_valid128 && cm_key128 == k) : (cm_valid80 && cm_key80 == k));
        if (!(m && hit)) begin
            if (w128) begin cm_valid128 = 1'b1; cm_key128 = k; end
            else      begin cm_valid80  = 1'b1; cm_key80  = k; end
        end
        sb.push_back('{odat: exp_o, hit: hit, lat: (m && !hit) ? 8'd63 : 8'd32});

        @(negedge clk);
        use128 = w128; tb_mode = m; tb_idat = d; tb_key = k; tb_start = 1'b1; chip_enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tb_start = 1'b0;
        e = sb.pop_front();
        check("cache_hit", {63'd0, s_hit}, {63'd0, e.hit});
        check("busy", {63'd0, s_busy}, 64'd1);
        // Later changes on the request inputs must not matter.
        tb_mode = ~m;
        tb_idat = {$urandom, $urandom};
        tb_key  = w128 ? {$urandom, $urandom, $urandom, $urandom} : {48'd0, $urandom, $urandom, 16'($urandom)};
        lat = 0; cyc = 0;
        gap_at = stress ? $urandom_range(3, 25) : -1;
        while (!s_done && cyc < 300) begin
            if (lat == 1) check("hit_pulse", {63'd0, s_hit}, 64'd0);
            if (lat == gap_at) begin
                chip_enable = 1'b0;
                repeat (10) begin
                    tb_start = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    @(negedge clk);
                    cyc++;
                end
                chip_enable = 1'b1;
            end
            if (stress) tb_start = 1'($urandom_range(0, 1));
            @(posedge clk);
            lat++; cyc++;
            @(negedge clk);
        end
        tb_start = 1'b0;
        check("done_seen", {63'd0, s_done}, 64'd1);
        check("latency", 64'(lat), 64'(e.lat));
        check("odat", s_odat, e.odat);
        extra = 0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            if (s_done) extra++;
        end
        check("extra_done", 64'(extra), 64'd0);
        check("ready_after", {63'd0, s_ready}, 64'd1);
        check("odat_hold", s_odat, e.odat);
    endtask

    // ---------------- directed sequence ----------------
    localparam logic [127:0] ONES80 = {48'd0, 80'hFFFF_FFFF_FFFF_FFFF_FFFF};
    localparam logic [63:0]  ONES64 = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        logic [127:0] pool [3];
        logic [127:0] ka, k;
        logic [63:0]  d;
        logic         m;
        int           ndone;

        rst = 1'b1; chip_enable = 1'b1; tb_start = 1'b0; tb_mode = 1'b0;
        tb_idat = 64'd0; tb_key = 128'd0; use128 = 1'b0;
        cm_valid80 = 1'b0; cm_valid128 = 1'b0; cm_key80 = 128'd0; cm_key128 = 128'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_ready", {63'd0, s_ready}, 64'd1);
        check("rst_busy", {63'd0, s_busy}, 64'd0);
        check("rst_odat", s_odat, 64'd0);
        check("rst_done", {63'd0, s_done}, 64'd0);
        check("rst_hit", {63'd0, s_hit}, 64'd0);

        // Published 80-bit encryption vectors.
        run_op(1'b0, 1'b0, 64'd0,  128'd0, 64'h5579_C138_7B22_8445, 1'b0);
        run_op(1'b0, 1'b0, 64'd0,  ONES80, 64'hE72C_46C0_F594_5049, 1'b0);
        run_op(1'b0, 1'b0, ONES64, 128'd0, 64'hA112_FFC7_2F68_417B, 1'b0);
        run_op(1'b0, 1'b0, ONES64, ONES80, 64'h3333_DCD3_2132_10D2, 1'b0);

        // Decrypt: miss after reset, then hit, then miss on a different key.
        do_reset();
        run_op(1'b0, 1'b1, 64'h3333_DCD3_2132_10D2, ONES80, ONES64, 1'b0);
        run_op(1'b0, 1'b1, 64'hE72C_46C0_F594_5049, ONES80, 64'd0, 1'b0);
        run_op(1'b0, 1'b1, 64'h5579_C138_7B22_8445, 128'd0, 64'd0, 1'b0);

        // Random traffic with stalls and stray start pulses.
        for (int i = 0; i < 3; i++) pool[i] = {48'd0, $urandom, $urandom, 16'($urandom)};
        for (int n = 0; n < 8; n++) begin
            k = pool[$urandom_range(0, 2)];
            d = {$urandom, $urandom};
            m = 1'($urandom_range(0, 1));
            run_op(1'b0, m, d, k, m ? m_dec(d, k, 80) : m_enc(d, k, 80), 1'b1);
        end

        // Abort at round 15: reset wins even with chip_enable low.
        ka = pool[0];
        d  = {$urandom, $urandom};
        run_op(1'b0, 1'b0, d, ka, m_enc(d, ka, 80), 1'b0);
        @(negedge clk);
        use128 = 1'b0; tb_mode = 1'b0; tb_idat = d; tb_key = ka; tb_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tb_start = 1'b0;
        repeat (14) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("abort_busy", {63'd0, s_busy}, 64'd1);
        chip_enable = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chip_enable = 1'b1;
        cm_valid80 = 1'b0; cm_valid128 = 1'b0;
        check("abort_ready", {63'd0, s_ready}, 64'd1);
        check("abort_busy0", {63'd0, s_busy}, 64'd0);
        check("abort_odat", s_odat, 64'd0);
        ndone = 0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (s_done) ndone++;
        end
        check("abort_no_done", 64'(ndone), 64'd0);
        d = {$urandom, $urandom};
        run_op(1'b0, 1'b1, d, ka, m_dec(d, ka, 80), 1'b0);

        // 128-bit key.
        run_op(1'b1, 1'b0, 64'd0, 128'd0, 64'h96DB_702A_2E69_00AF, 1'b0);
        run_op(1'b1, 1'b1, 64'h96DB_702A_2E69_00AF, 128'd0, 64'd0, 1'b0);
        k = {$urandom, $urandom, $urandom, $urandom};
        d = {$urandom, $urandom};
        run_op(1'b1, 1'b1, d, k, m_dec(d, k, 128), 1'b1);
        run_op(1'b1, 1'b0, d, k, m_enc(d, k, 128), 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
